instr_encoder: RTL and testbench

Program loader that encodes ALU micro-ops (decoder op encoding plus register/immediate fields) into RV32I instruction words and writes them into instruction memory. It is the producer side of the decode path: words it writes are what the decoder later fetches and decodes. It has a valid/ready input, a DEPTH-entry FIFO of encoded words, and a sequential word-address counter on the memory write port.

---
 rtl/instr_encoder.sv | 127 ++++++++++++
 tb/tb_instr_encoder.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes ALU micro-ops into RV32I words and streams them into instruction memory
// Optional: INSTR_ENC_X0_FILTER_EN drops legal non-NOP micro-ops that target x0.
module instr_encoder #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_op,
   input  logic              in_use_imm,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [11:0]       in_imm,
   input  logic              in_last,
   output logic              imem_we,
   input  logic              imem_ready,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err_illegal,
   output logic [15:0]       wr_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state, state_nx;

   logic [31:0]      fifo_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             full, empty, accept, push, pop, legal, keep, is_nop;
   logic [31:0]      enc_word;

   assign full   = (count == (PTR_W+1)'(DEPTH));
   assign empty  = (count == '0);
   assign accept = in_valid && in_ready;
   assign push   = accept && keep;
   assign pop    = imem_we && imem_ready;
   assign is_nop = (in_op == 6'b111111);

   always_comb begin
      legal    = 1'b1;
      enc_word = NOP_WORD;
      case (in_op)
         6'b000000: enc_word = in_use_imm ? {in_imm, in_rs1, 3'b000, in_rd, 7'b0010011}
                                          : {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
         6'b000001: begin
            if (in_use_imm) legal = 1'b0;
            else enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
         end
         6'b000010: enc_word = in_use_imm ? {in_imm, in_rs1, 3'b111, in_rd, 7'b0010011}
                                          : {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, 7'b0110011};
         6'b111111: enc_word = NOP_WORD;
         default:   legal = 1'b0;
      endcase
   end

`ifdef INSTR_ENC_X0_FILTER_EN
   assign keep = !(legal && !is_nop && (in_rd == 5'd0));
`else
   assign keep = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (accept && in_last) state_nx = DRAIN;
         DRAIN:   if (empty) state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == RUN) && !full;
      busy     = (state != IDLE);
      done     = (state == DONE);
   end

   // Storage has no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= enc_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         imem_addr   <= '0;
         wr_count    <= '0;
         err_illegal <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + (PTR_W+1)'(1);
         else if (pop && !push) count <= count - (PTR_W+1)'(1);

         if (state == IDLE && start) begin
            imem_addr   <= base_addr & ~ADDR_W'(3);
            wr_count    <= '0;
            err_illegal <= 1'b0;
         end else begin
            if (pop) begin
               imem_addr <= imem_addr + ADDR_W'(4);
               if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end
            if (accept && !legal) err_illegal <= 1'b1;
         end
      end
   end

   assign imem_we    = !empty;
   assign imem_wdata = empty ? 32'h0 : fifo_mem[rd_ptr];
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder against a field-level model
// Expectations follow INSTR_ENC_X0_FILTER_EN when defined.
module tb_instr_encoder;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst_n, start, in_valid, in_ready, in_use_imm, in_last;
   logic [ADDR_W-1:0] base_addr, imem_addr;
   logic [5:0]        in_op;
   logic [4:0]        in_rd, in_rs1, in_rs2;
   logic [11:0]       in_imm;
   logic              imem_we, imem_ready, busy, done, err_illegal;
   logic [31:0]       imem_wdata;
   logic [15:0]       wr_count;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_use_imm(in_use_imm),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
      .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .busy(busy), .done(done), .err_illegal(err_illegal), .wr_count(wr_count)
   );

   typedef struct {
      logic [5:0]  op;
      logic        use_imm;
      logic [4:0]  rd, rs1, rs2;
      logic [11:0] imm;
   } uop_t;

   int checks = 0;
   int errors = 0;

   uop_t              seq[$];
   logic [31:0]       got_data[$], exp_data[$];
   logic [ADDR_W-1:0] got_addr[$], exp_addr[$];
   logic              exp_err;
   int                done_cnt, blocked_acc, unstable, timeout;

   function automatic bit is_legal(uop_t u);
      return (u.op == 6'd0) || (u.op == 6'd1 && !u.use_imm) || (u.op == 6'd2) || (u.op == 6'd63);
   endfunction

   function automatic bit dropped(uop_t u);
`ifdef INSTR_ENC_X0_FILTER_EN
      return is_legal(u) && u.op != 6'd63 && u.rd == 5'd0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] ref_word(uop_t u);
      longint w, f3, f7;
      if (!is_legal(u) || u.op == 6'd63) return 32'h13;
      f3 = (u.op == 6'd2) ? 7 : 0;
      f7 = (u.op == 6'd1) ? 32 : 0;
      if (u.use_imm)
         w = longint'(u.imm) * (1 << 20) + longint'(u.rs1) * (1 << 15) + f3 * (1 << 12)
             + longint'(u.rd) * (1 << 7) + 19;
      else
         w = f7 * (1 << 25) + longint'(u.rs2) * (1 << 20) + longint'(u.rs1) * (1 << 15)
             + f3 * (1 << 12) + longint'(u.rd) * (1 << 7) + 51;
      return w[31:0];
   endfunction

   function automatic uop_t mk(input int op, input bit ui, input int rd, input int rs1,
                               input int rs2, input int imm);
      uop_t u;
      u.op = 6'(op); u.use_imm = ui; u.rd = 5'(rd); u.rs1 = 5'(rs1); u.rs2 = 5'(rs2);
      u.imm = 12'(imm);
      return u;
   endfunction

   function automatic uop_t rand_uop(input bit legal_only);
      int k;
      uop_t u;
      k = legal_only ? $urandom_range(0, 7) : $urandom_range(0, 9);
      u.op = (k < 3) ? 6'd0 : (k < 5) ? 6'd1 : (k < 7) ? 6'd2 : (k < 8) ? 6'd63
                     : 6'($urandom_range(3, 62));
      u.use_imm = (legal_only && u.op == 6'd1) ? 1'b0 : 1'($urandom_range(0, 1));
      u.rd  = legal_only ? 5'($urandom_range(1, 31)) : 5'($urandom);
      u.rs1 = 5'($urandom);
      u.rs2 = 5'($urandom);
      u.imm = 12'($urandom);
      return u;
   endfunction

   task automatic build_exp(input logic [ADDR_W-1:0] base);
      logic [ADDR_W-1:0] a;
      exp_data.delete(); exp_addr.delete(); exp_err = 1'b0;
      a = base & ~ADDR_W'(3);
      foreach (seq[i]) begin
         if (!is_legal(seq[i])) exp_err = 1'b1;
         if (!dropped(seq[i])) begin
            exp_data.push_back(ref_word(seq[i]));
            exp_addr.push_back(a);
            a = ADDR_W'(a + 4);
         end
      end
   endtask

   // mode 1: random valid/ready gaps; otherwise imem_ready held low for the first 'hold' cycles
   task automatic run_seq(input logic [ADDR_W-1:0] base, input int mode, input int hold);
      got_data.delete(); got_addr.delete();
      done_cnt = 0; blocked_acc = 0; unstable = 0; timeout = 0;
      @(negedge clk); start = 1'b1; base_addr = base;
      @(negedge clk); start = 1'b0;
      fork
         begin
            int i = 0;
            int cyc = 0;
            while (i < seq.size() && cyc < 3000) begin
               @(negedge clk); cyc++;
               in_op = seq[i].op; in_use_imm = seq[i].use_imm; in_rd = seq[i].rd;
               in_rs1 = seq[i].rs1; in_rs2 = seq[i].rs2; in_imm = seq[i].imm;
               in_last = (i == seq.size() - 1);
               in_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
               if (in_valid && in_ready) begin
                  if (cyc <= hold) blocked_acc++;
                  i++;
               end
            end
            @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
         end
         begin
            int cyc = 0;
            bit pw = 1'b0;
            logic [31:0] pd = '0;
            logic [ADDR_W-1:0] pa = '0;
            while (cyc < 3000) begin
               @(negedge clk); cyc++;
               imem_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : (cyc > hold);
               if (pw && (imem_wdata !== pd || imem_addr !== pa)) unstable++;
               pw = imem_we && !imem_ready; pd = imem_wdata; pa = imem_addr;
               if (imem_we && imem_ready) begin
                  got_data.push_back(imem_wdata);
                  got_addr.push_back(imem_addr);
               end
               if (done) begin done_cnt++; break; end
            end
            if (cyc >= 3000) timeout = 1;
            @(negedge clk);
            if (done) done_cnt++;
         end
      join
      imem_ready = 1'b1;
   endtask

   task automatic test_reset();
      checks++;
      if ({in_ready, imem_we, busy, done, err_illegal, imem_addr, imem_wdata, wr_count} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b we=%b busy=%b done=%b err=%b addr=%h data=%h cnt=%0d, expected all 0",
                  in_ready, imem_we, busy, done, err_illegal, imem_addr, imem_wdata, wr_count);
      end
   endtask

   task automatic test_basic();
      logic [31:0] kw [3];
      kw[0] = 32'h003100B3; kw[1] = 32'h407302B3; kw[2] = 32'h0FF27213;
      seq = '{mk(0, 0, 1, 2, 3, 0), mk(1, 0, 5, 6, 7, 0), mk(2, 1, 4, 4, 0, 12'h0FF)};
      run_seq(10'h040, 0, 0);
      checks++;
      if (got_data.size() != 3 || timeout != 0) begin
         errors++; $display("FAIL basic_count: got %0d words (timeout=%0d), expected 3", got_data.size(), timeout);
      end else
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_data[i] !== kw[i] || got_addr[i] !== ADDR_W'(10'h040 + 4 * i)) begin
               errors++;
               $display("FAIL basic_word%0d: got %h@%h, expected %h@%h", i, got_data[i], got_addr[i],
                        kw[i], ADDR_W'(10'h040 + 4 * i));
            end
         end
      checks++;
      if (done_cnt != 1 || wr_count !== 16'd3 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: got done_cycles=%0d wr_count=%0d busy=%b, expected 1 3 0", done_cnt, wr_count, busy);
      end
   endtask

   task automatic test_backpressure();
      logic [ADDR_W-1:0] base;
      seq.delete();
      for (int i = 0; i < 6; i++) seq.push_back(rand_uop(1'b1));
      base = ADDR_W'($urandom);
      build_exp(base);
      run_seq(base, 2, 20);
      checks++;
      if (blocked_acc != DEPTH || unstable != 0) begin
         errors++;
         $display("FAIL bp_stall: got accepts_while_blocked=%0d unstable=%0d, expected %0d 0", blocked_acc, unstable, DEPTH);
      end
      checks++;
      if (got_data.size() != exp_data.size()) begin
         errors++; $display("FAIL bp_count: got %0d words, expected %0d", got_data.size(), exp_data.size());
      end else
         foreach (exp_data[i]) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_addr[i] !== exp_addr[i]) begin
               errors++;
               $display("FAIL bp_word%0d: got %h@%h, expected %h@%h", i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
            end
         end
   endtask

   task automatic test_illegal();
      seq = '{mk(5, 0, 3, 1, 2, 0), mk(1, 1, 7, 8, 0, 12'h123)};
      run_seq(10'h100, 0, 0);
      checks++;
      if (got_data.size() != 2) begin
         errors++; $display("FAIL illegal_count: got %0d words, expected 2", got_data.size());
      end else if (got_data[0] !== 32'h13 || got_data[1] !== 32'h13) begin
         errors++; $display("FAIL illegal_words: got %h %h, expected 00000013 00000013", got_data[0], got_data[1]);
      end
      checks++;
      if (err_illegal !== 1'b1 || wr_count !== 16'd2) begin
         errors++; $display("FAIL illegal_flag: got err=%b wr_count=%0d, expected 1 2", err_illegal, wr_count);
      end
   endtask

   task automatic test_wrap();
      seq = '{mk(63, 0, 0, 0, 0, 0), mk(63, 0, 0, 0, 0, 0)};
      run_seq(10'h3FE, 0, 0);
      checks++;
      if (got_data.size() != 2) begin
         errors++; $display("FAIL wrap_count: got %0d words, expected 2", got_data.size());
      end else if (got_addr[0] !== 10'h3FC || got_addr[1] !== 10'h000 || got_data[1] !== 32'h13) begin
         errors++;
         $display("FAIL wrap_addr: got %h %h data %h, expected 3fc 000 00000013", got_addr[0], got_addr[1], got_data[1]);
      end
      checks++;
      if (err_illegal !== 1'b0) begin
         errors++; $display("FAIL wrap_err_cleared: got %b, expected 0", err_illegal);
      end
   endtask

   task automatic test_async_reset();
      imem_ready = 1'b0;
      @(negedge clk); start = 1'b1; base_addr = 10'h100;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_op = 6'd0; in_use_imm = 1'b0; in_rd = 5'(i + 1);
         in_rs1 = 5'd2; in_rs2 = 5'd3; in_last = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b0; start = 1'b1; base_addr = 10'h200;
      @(negedge clk); start = 1'b0;
      checks++;
      if (imem_addr !== 10'h100 || imem_we !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL start_ignored: got addr=%h we=%b busy=%b, expected 100 1 1", imem_addr, imem_we, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, imem_we, busy, done, err_illegal, imem_addr, imem_wdata, wr_count} !== '0) begin
         errors++;
         $display("FAIL async_reset: got rdy=%b we=%b busy=%b addr=%h data=%h, expected all 0",
                  in_ready, imem_we, busy, imem_addr, imem_wdata);
      end
      @(negedge clk); rst_n = 1'b1; imem_ready = 1'b1;
      seq = '{mk(0, 0, 1, 2, 3, 0), mk(1, 0, 5, 6, 7, 0), mk(2, 1, 4, 4, 0, 12'h0FF)};
      build_exp(10'h080);
      run_seq(10'h080, 0, 0);
      checks++;
      if (got_data.size() != 3 || got_data[0] !== exp_data[0] || got_addr[2] !== 10'h088 || done_cnt != 1) begin
         errors++;
         $display("FAIL post_reset_seq: got %0d words first=%h done_cycles=%0d, expected 3 %h 1",
                  got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'hx, done_cnt, exp_data[0]);
      end
   endtask

   task automatic test_x0();
      logic [15:0] exp_cnt;
      seq = '{mk(0, 0, 0, 1, 2, 0), mk(63, 0, 0, 0, 0, 0)};
      run_seq(10'h010, 0, 0);
`ifdef INSTR_ENC_X0_FILTER_EN
      exp_cnt = 16'd1;
      checks++;
      if (got_data.size() != 1 || got_data[0] !== 32'h13) begin
         errors++; $display("FAIL x0_filter: got %0d words, expected only 00000013", got_data.size());
      end
`else
      exp_cnt = 16'd2;
      checks++;
      if (got_data.size() != 2 || got_data[0] !== 32'h00208033 || got_data[1] !== 32'h13) begin
         errors++; $display("FAIL x0_write: got %0d words, expected 00208033 00000013", got_data.size());
      end
`endif
      checks++;
      if (wr_count !== exp_cnt || done_cnt != 1) begin
         errors++; $display("FAIL x0_count: got wr_count=%0d done=%0d, expected %0d 1", wr_count, done_cnt, exp_cnt);
      end
   endtask

   task automatic test_random();
      logic [ADDR_W-1:0] base;
      for (int it = 0; it < 8; it++) begin
         seq.delete();
         for (int i = 0; i < $urandom_range(1, 9); i++) seq.push_back(rand_uop(1'b0));
         base = ADDR_W'($urandom);
         build_exp(base);
         run_seq(base, 1, 0);
         checks++;
         if (got_data.size() != exp_data.size() || done_cnt != 1 || timeout != 0) begin
            errors++;
            $display("FAIL rand%0d_count: got %0d words done=%0d timeout=%0d, expected %0d 1 0",
                     it, got_data.size(), done_cnt, timeout, exp_data.size());
         end else
            foreach (exp_data[i]) begin
               checks++;
               if (got_data[i] !== exp_data[i] || got_addr[i] !== exp_addr[i]) begin
                  errors++;
                  $display("FAIL rand%0d_word%0d: got %h@%h, expected %h@%h", it, i, got_data[i], got_addr[i],
                           exp_data[i], exp_addr[i]);
               end
            end
         checks++;
         if (wr_count !== 16'(exp_data.size()) || err_illegal !== exp_err) begin
            errors++;
            $display("FAIL rand%0d_status: got wr_count=%0d err=%b, expected %0d %b", it, wr_count, err_illegal,
                     exp_data.size(), exp_err);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_op = '0; in_use_imm = 1'b0;
      in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0; imem_ready = 1'b1;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_basic();
      test_backpressure();
      test_illegal();
      test_wrap();
      test_async_reset();
      test_x0();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
